// File: rtl/ks_voice_mixer.sv
// Four-voice Karplus-Strong mixer: a sequential multiply-accumulate over the
// voice samples, saturated to 16 bits, plus a free-running left-justified
// serial codec interface that repeats the latest mix on both channels.
module ks_voice_mixer #(
    parameter int BCLK_DIV = 4,
    parameter int NVOICE   = 4
) (
    input  logic        clk_i,
    input  logic        aclr_n_i,
    input  logic        clk_sample_i,
    input  logic [15:0] sample0_i,
    input  logic [15:0] sample1_i,
    input  logic [15:0] sample2_i,
    input  logic [15:0] sample3_i,
    input  logic [3:0]  gain0_i,
    input  logic [3:0]  gain1_i,
    input  logic [3:0]  gain2_i,
    input  logic [3:0]  gain3_i,
    input  logic        flag_clr_i,
    output logic [15:0] mix_o,
    output logic        mix_valid_o,
    output logic        clip_o,
    output logic        overrun_o,
    output logic        dac_bclk_o,
    output logic        dac_lrck_o,
    output logic        dac_data_o
);

    localparam int DivW = $clog2(BCLK_DIV);

    typedef enum logic [2:0] {
        IDLE,
        MAC0,
        MAC1,
        MAC2,
        MAC3,
        SAT
    } state_t;

    state_t              state_q, state_d;
    logic                sync1_q, sync2_q, sync3_q, strobe_q;
    logic signed [15:0]  sampleHeld_q [NVOICE];
    logic        [3:0]   gainHeld_q   [NVOICE];
    logic signed [21:0]  accum_q, accum_d;
    logic        [15:0]  mix_q, mix_d;
    logic                mixValid_q;
    logic                clip_q, clip_d;
    logic                overrun_q, overrun_d;
    logic                load, mixUpdate, overrunSet;
    logic        [1:0]   voiceIdx;
    logic signed [20:0]  productWide;
    logic signed [17:0]  shifted;
    logic        [15:0]  satVal;
    logic                satHit;

    logic [DivW-1:0]     divCnt_q, divCnt_d;
    logic                bclk_q, bclk_d;
    logic [4:0]          bitCnt_q, bitCnt_d;
    logic [15:0]         shift_q, shift_d;
    logic [15:0]         word_q, word_d;
    logic                bclkTick, bclkFall;

    // Bring the sample strobe into the clk domain and turn its rising edge into a registered one-cycle pulse.
    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            sync3_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= clk_sample_i;
            sync2_q  <= sync1_q;
            sync3_q  <= sync2_q;
            strobe_q <= sync2_q & ~sync3_q;
        end
    end

    // Snapshot all voices at the start of a mix so the inputs may change while the MAC runs.
    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            for (int v = 0; v < NVOICE; v++) begin
                sampleHeld_q[v] <= '0;
                gainHeld_q[v]   <= '0;
            end
        end else if (load) begin
            sampleHeld_q[0] <= sample0_i;
            sampleHeld_q[1] <= sample1_i;
            sampleHeld_q[2] <= sample2_i;
            sampleHeld_q[3] <= sample3_i;
            gainHeld_q[0]   <= gain0_i;
            gainHeld_q[1]   <= gain1_i;
            gainHeld_q[2]   <= gain2_i;
            gainHeld_q[3]   <= gain3_i;
        end
    end

    // Select which held voice feeds the multiplier in the current MAC state.
    always_comb begin
        voiceIdx = 2'd0;
        case (state_q)
            MAC1:    voiceIdx = 2'd1;
            MAC2:    voiceIdx = 2'd2;
            MAC3:    voiceIdx = 2'd3;
            default: voiceIdx = 2'd0;
        endcase
    end

    // The zero-extended gain makes this a signed-by-unsigned product; it never exceeds 20 significant bits.
    assign productWide = sampleHeld_q[voiceIdx] * $signed({1'b0, gainHeld_q[voiceIdx]});

    // Divide the sum by 16 and clamp it into the 16-bit signed output range.
    always_comb begin
        shifted = 18'(accum_q >>> 4);
        satVal  = shifted[15:0];
        satHit  = 1'b0;
        if (shifted > 18'sd32767) begin
            satVal = 16'h7FFF;
            satHit = 1'b1;
        end else if (shifted < -18'sd32768) begin
            satVal = 16'h8000;
            satHit = 1'b1;
        end
    end

    // Mixing sequencer: one voice per state, then saturate; strobes arriving while busy are dropped and flagged.
    always_comb begin
        state_d    = state_q;
        accum_d    = accum_q;
        load       = 1'b0;
        mixUpdate  = 1'b0;
        overrunSet = strobe_q && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (strobe_q) begin
                    state_d = MAC0;
                    accum_d = '0;
                    load    = 1'b1;
                end
            end
            MAC0: begin
                accum_d = accum_q + 22'(productWide);
                state_d = MAC1;
            end
            MAC1: begin
                accum_d = accum_q + 22'(productWide);
                state_d = MAC2;
            end
            MAC2: begin
                accum_d = accum_q + 22'(productWide);
                state_d = MAC3;
            end
            MAC3: begin
                accum_d = accum_q + 22'(productWide);
                state_d = SAT;
            end
            SAT: begin
                mixUpdate = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output word and sticky flags; a set event in the same cycle as a clear keeps the flag set.
    always_comb begin
        mix_d     = mixUpdate ? satVal : mix_q;
        clip_d    = (clip_q & ~flag_clr_i) | (mixUpdate & satHit);
        overrun_d = (overrun_q & ~flag_clr_i) | overrunSet;
    end

    // Mixer state registers.
    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            state_q    <= IDLE;
            accum_q    <= '0;
            mix_q      <= '0;
            mixValid_q <= 1'b0;
            clip_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            accum_q    <= accum_d;
            mix_q      <= mix_d;
            mixValid_q <= mixUpdate;
            clip_q     <= clip_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bclkTick = (divCnt_q == DivW'(BCLK_DIV - 1));
    assign bclkFall = bclkTick & bclk_q;

    // Bit clock divider, frame position and serializer; the next-cycle mix is loaded so a coincident update is not missed.
    always_comb begin
        divCnt_d = divCnt_q + DivW'(1);
        bclk_d   = bclk_q;
        bitCnt_d = bitCnt_q;
        shift_d  = shift_q;
        word_d   = word_q;
        if (bclkTick) begin
            divCnt_d = '0;
            bclk_d   = ~bclk_q;
        end
        if (bclkFall) begin
            bitCnt_d = bitCnt_q + 5'd1;
            if (bitCnt_q == 5'd31) begin
                word_d  = mix_d;
                shift_d = mix_d;
            end else if (bitCnt_q == 5'd15) begin
                shift_d = word_q;
            end else begin
                shift_d = {shift_q[14:0], 1'b0};
            end
        end
    end

    // Codec interface registers.
    always_ff @(posedge clk_i or negedge aclr_n_i) begin
        if (!aclr_n_i) begin
            divCnt_q <= '0;
            bclk_q   <= 1'b0;
            bitCnt_q <= '0;
            shift_q  <= '0;
            word_q   <= '0;
        end else begin
            divCnt_q <= divCnt_d;
            bclk_q   <= bclk_d;
            bitCnt_q <= bitCnt_d;
            shift_q  <= shift_d;
            word_q   <= word_d;
        end
    end

    assign mix_o       = mix_q;
    assign mix_valid_o = mixValid_q;
    assign clip_o      = clip_q;
    assign overrun_o   = overrun_q;
    assign dac_bclk_o  = bclk_q;
    assign dac_lrck_o  = bitCnt_q[4];
    assign dac_data_o  = shift_q[15];

endmodule

// File: tb/tb_ks_voice_mixer.sv
// Testbench for ks_voice_mixer: scoreboard of expected mixes checked against
// mix_valid, sticky flag behaviour, overrun, reset abort and the serial stream.
module tb_ks_voice_mixer;

    logic        clk = 1'b0;
    logic        aclr_n_i;
    logic        clk_sample_i;
    logic [15:0] sample0_i, sample1_i, sample2_i, sample3_i;
    logic [3:0]  gain0_i, gain1_i, gain2_i, gain3_i;
    logic        flag_clr_i;
    logic [15:0] mix_o;
    logic        mix_valid_o, clip_o, overrun_o;
    logic        dac_bclk_o, dac_lrck_o, dac_data_o;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] expQ[$];
    logic        clipExp = 1'b0;

    ks_voice_mixer #(.BCLK_DIV(4), .NVOICE(4)) dut (
        .clk_i(clk), .aclr_n_i(aclr_n_i), .clk_sample_i(clk_sample_i),
        .sample0_i(sample0_i), .sample1_i(sample1_i), .sample2_i(sample2_i), .sample3_i(sample3_i),
        .gain0_i(gain0_i), .gain1_i(gain1_i), .gain2_i(gain2_i), .gain3_i(gain3_i),
        .flag_clr_i(flag_clr_i), .mix_o(mix_o), .mix_valid_o(mix_valid_o),
        .clip_o(clip_o), .overrun_o(overrun_o),
        .dac_bclk_o(dac_bclk_o), .dac_lrck_o(dac_lrck_o), .dac_data_o(dac_data_o)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    // Hang guard.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference mix: weighted sum, divide by 16, clamp to 16-bit signed.
    function automatic void model(input logic [15:0] s0, s1, s2, s3,
                                  input logic [3:0] g0, g1, g2, g3,
                                  output logic [15:0] m, output logic c);
        int acc;
        acc = int'($signed(s0)) * int'(g0) + int'($signed(s1)) * int'(g1)
            + int'($signed(s2)) * int'(g2) + int'($signed(s3)) * int'(g3);
        acc = acc >>> 4;
        if (acc > 32767) begin
            m = 16'h7FFF; c = 1'b1;
        end else if (acc < -32768) begin
            m = 16'h8000; c = 1'b1;
        end else begin
            m = 16'(acc); c = 1'b0;
        end
    endfunction

    task automatic set_voices(input logic [15:0] s0, s1, s2, s3, input logic [3:0] g0, g1, g2, g3);
        sample0_i = s0; sample1_i = s1; sample2_i = s2; sample3_i = s3;
        gain0_i = g0; gain1_i = g1; gain2_i = g2; gain3_i = g3;
    endtask

    task automatic clear_flags();
        @(negedge clk);
        flag_clr_i = 1'b1;
        @(negedge clk);
        flag_clr_i = 1'b0;
        clipExp = 1'b0;
    endtask

    task automatic run_mix(input string name, input logic [15:0] s0, s1, s2, s3,
                           input logic [3:0] g0, g1, g2, g3);
        logic [15:0] expMix;
        logic        expClip;
        logic [15:0] want;
        int          lat;
        bit          seen;
        model(s0, s1, s2, s3, g0, g1, g2, g3, expMix, expClip);
        expQ.push_back(expMix);
        if (expClip) clipExp = 1'b1;
        @(negedge clk);
        set_voices(s0, s1, s2, s3, g0, g1, g2, g3);
        clk_sample_i = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) clk_sample_i = 1'b0;
            if (mix_valid_o === 1'b1) seen = 1'b1;
        end
        clk_sample_i = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("[TB] FAIL %s_timeout: no mix_valid within %0d cycles", name, lat);
            want = expQ.pop_front();
            return;
        end
        if (lat != 9) begin
            errors++;
            $display("[TB] FAIL %s_latency: got %0d edges, want 9", name, lat);
        end
        want = expQ.pop_front();
        checks++;
        if (mix_o !== want) begin
            errors++;
            $display("[TB] FAIL %s_mix: got %h, want %h", name, mix_o, want);
        end
        checks++;
        if (clip_o !== clipExp) begin
            errors++;
            $display("[TB] FAIL %s_clip: got %b, want %b", name, clip_o, clipExp);
        end
        @(negedge clk);
        checks++;
        if (mix_valid_o !== 1'b0 || mix_o !== want) begin
            errors++;
            $display("[TB] FAIL %s_hold: valid=%b mix=%h, want valid=0 mix=%h", name, mix_valid_o, mix_o, want);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        logic [21:0] got;
        got = {mix_o, mix_valid_o, clip_o, overrun_o, dac_bclk_o, dac_lrck_o, dac_data_o};
        checks++;
        if (got !== 22'd0) begin
            errors++;
            $display("[TB] FAIL %s: outputs {mix,valid,clip,ovr,bclk,lrck,data}=%h, want 0", name, got);
        end
    endtask

    task automatic test_reset();
        aclr_n_i = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_outputs");
        aclr_n_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mix_o !== 16'h0000 || dac_data_o !== 1'b0 || dac_lrck_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset: mix=%h data=%b lrck=%b, want 0 0 0", mix_o, dac_data_o, dac_lrck_o);
        end
    endtask

    task automatic test_basic();
        run_mix("basic", 16'h1000, 16'h1000, 16'h1000, 16'h1000, 4'd8, 4'd8, 4'd8, 4'd8);
        run_mix("mixed_signs", 16'h0800, 16'hF800, 16'h1234, 16'hFF00, 4'd15, 4'd3, 4'd7, 4'd1);
    endtask

    task automatic test_pos_sat();
        run_mix("pos_sat", 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 4'd15, 4'd15, 4'd15, 4'd15);
        clear_flags();
        checks++;
        if (clip_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clip_clear: got %b, want 0", clip_o);
        end
    endtask

    task automatic test_neg_sat();
        run_mix("neg_sat", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 4'd15, 4'd15, 4'd15, 4'd15);
        clear_flags();
    endtask

    task automatic test_random();
        for (int i = 0; i < 4; i++) begin
            run_mix("random", 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                    4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            clear_flags();
        end
    endtask

    task automatic test_overrun();
        logic [15:0] expMix;
        logic        expClip;
        logic [15:0] want;
        int          pulses;
        int          firstLat;
        clear_flags();
        model(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4'd2, 4'd2, 4'd2, 4'd2, expMix, expClip);
        expQ.push_back(expMix);
        @(negedge clk);
        set_voices(16'h0100, 16'h0200, 16'h0300, 16'h0400, 4'd2, 4'd2, 4'd2, 4'd2);
        clk_sample_i = 1'b1;
        pulses = 0;
        firstLat = -1;
        for (int lat = 1; lat <= 30; lat++) begin
            @(negedge clk);
            if (lat == 1) clk_sample_i = 1'b0;
            if (lat == 3) clk_sample_i = 1'b1;
            if (lat == 5) clk_sample_i = 1'b0;
            if (mix_valid_o === 1'b1) begin
                pulses++;
                if (firstLat < 0) begin
                    firstLat = lat;
                    want = expQ.pop_front();
                    checks++;
                    if (mix_o !== want) begin
                        errors++;
                        $display("[TB] FAIL overrun_mix: got %h, want %h", mix_o, want);
                    end
                end
            end
        end
        checks++;
        if (pulses != 1 || firstLat != 9) begin
            errors++;
            $display("[TB] FAIL overrun_pulses: got %0d pulses first at %0d, want 1 at 9", pulses, firstLat);
        end
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_flag: got %b, want 1", overrun_o);
        end
        clear_flags();
        checks++;
        if (overrun_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_clear: got %b, want 0", overrun_o);
        end
    endtask

    task automatic test_serial();
        logic [31:0] bits;
        int          cyc, rises, firstRise, secondRise;
        logic        prevB, prevL, lrckLeft, lrckRight;
        bit          found;
        run_mix("serial_mix", 16'hA5C3, 16'hA5C3, 16'h0000, 16'h0000, 4'd8, 4'd8, 4'd0, 4'd0);
        found = 1'b0;
        cyc = 0;
        prevL = dac_lrck_o;
        while (!found && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (prevL && !dac_lrck_o) found = 1'b1;
            prevL = dac_lrck_o;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("[TB] FAIL lrck_fall: none within %0d cycles", cyc);
            return;
        end
        cyc = 0; rises = 0; firstRise = 0; secondRise = 0; bits = '0;
        lrckLeft = 1'b1; lrckRight = 1'b0;
        prevB = dac_bclk_o;
        found = 1'b0;
        while (!found && cyc < 600) begin
            @(negedge clk);
            cyc++;
            if (!prevB && dac_bclk_o && rises < 32) begin
                bits = {bits[30:0], dac_data_o};
                rises++;
                if (rises == 1) begin firstRise = cyc; lrckLeft = dac_lrck_o; end
                if (rises == 2) secondRise = cyc;
                if (rises == 17) lrckRight = dac_lrck_o;
            end
            if (prevL && !dac_lrck_o) found = 1'b1;
            prevB = dac_bclk_o;
            prevL = dac_lrck_o;
        end
        checks++;
        if (!found || cyc != 256 || rises != 32) begin
            errors++;
            $display("[TB] FAIL frame_length: got %0d clk and %0d bclk periods, want 256 and 32", cyc, rises);
        end
        checks++;
        if (secondRise - firstRise != 8) begin
            errors++;
            $display("[TB] FAIL bclk_period: got %0d clk, want 8", secondRise - firstRise);
        end
        checks++;
        if (lrckLeft !== 1'b0 || lrckRight !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lrck_level: got left=%b right=%b, want 0 1", lrckLeft, lrckRight);
        end
        checks++;
        if (bits[31:16] !== 16'hA5C3) begin
            errors++;
            $display("[TB] FAIL left_word: got %h, want a5c3", bits[31:16]);
        end
        checks++;
        if (bits[15:0] !== 16'hA5C3) begin
            errors++;
            $display("[TB] FAIL right_word: got %h, want a5c3", bits[15:0]);
        end
    endtask

    task automatic test_reset_mid_mac();
        int pulses;
        @(negedge clk);
        set_voices(16'h7000, 16'h7000, 16'h7000, 16'h7000, 4'd9, 4'd9, 4'd9, 4'd9);
        clk_sample_i = 1'b1;
        for (int lat = 1; lat <= 5; lat++) begin
            @(negedge clk);
            if (lat == 2) clk_sample_i = 1'b0;
        end
        aclr_n_i = 1'b0;
        #1;
        check_all_zero("reset_mid_mac");
        @(negedge clk);
        aclr_n_i = 1'b1;
        clipExp = 1'b0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (mix_valid_o === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || mix_o !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL aborted_mix: got %0d pulses mix=%h, want 0 pulses mix=0000", pulses, mix_o);
        end
        run_mix("after_reset", 16'h0400, 16'h0400, 16'h0400, 16'h0400, 4'd4, 4'd4, 4'd4, 4'd4);
    endtask

    // Test sequence.
    initial begin
        aclr_n_i = 1'b0;
        clk_sample_i = 1'b0;
        flag_clr_i = 1'b0;
        set_voices(16'h0, 16'h0, 16'h0, 16'h0, 4'd0, 4'd0, 4'd0, 4'd0);
        test_reset();
        test_basic();
        test_pos_sat();
        test_neg_sat();
        test_random();
        test_overrun();
        test_serial();
        test_reset_mid_mac();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ks_voice_mixer.md
KS_VOICE_MIXER -- requirements
Module: ks_voice_mixer

Interface
REQ-001 Parameter BCLK_DIV, default 4, is the number of clk cycles per dac_bclk half-period and SHALL be an integer ≥2.
REQ-002 Parameter NVOICE, default 4, is the number of voice inputs and SHALL be fixed at 4 in this revision.
REQ-003 clk  in  1  system clock; all logic SHALL be on its rising edge.
REQ-004 aclr_n  in  1  reset; one clock, reset asynchronous and active-low.
REQ-005 clk_sample  in  1  audio sample strobe, asynchronous to clk.
REQ-006 sample0..sample3  in  16 each  signed two's-complement voice samples from the Karplus-Strong voices.
REQ-007 gain0..gain3  in  4 each  unsigned per-voice volume, value g means g/16.
REQ-008 flag_clr  in  1  synchronous clear of the sticky flags.
REQ-009 mix  out  16  signed saturated mix result.
REQ-010 mix_valid  out  1  one-clk pulse when mix updates.
REQ-011 clip  out  1  sticky saturation flag.
REQ-012 overrun  out  1  sticky flag for a sample strobe lost during mixing.
REQ-013 dac_bclk, dac_lrck, dac_data  out  1 each  serial codec interface.

Function
REQ-014 clk_sample SHALL pass through a 2-flop synchronizer; a third flop SHALL form a one-cycle rising-edge pulse (edge = s2 & ~s3), giving 3 clk edges from clk_sample rise to the pulse.
REQ-015 FSM states SHALL be IDLE, MAC0, MAC1, MAC2, MAC3, SAT; on reset the FSM SHALL enter IDLE.
REQ-016 IDLE -> MAC0 on the edge pulse, which SHALL also clear the accumulator and latch all four samples and gains into holding registers.
REQ-017 In MACk the FSM SHALL add signed(sample_k) × unsigned(gain_k) (20-bit signed product) into a 22-bit signed accumulator, then advance to MAC(k+1); MAC3 SHALL advance to SAT.
REQ-018 In SAT the FSM SHALL arithmetic-shift the accumulator right by 4, saturate to 16 bits (>32767 -> 32767, <-32768 -> -32768), and return to IDLE.
REQ-019 mix and mix_valid SHALL update on the clk edge that leaves SAT, i.e. 6 clk edges after the edge pulse asserts; mix SHALL hold its value until the next update.
REQ-020 clip SHALL set in the same cycle mix_valid asserts with a saturated result and remain set until flag_clr.
REQ-021 An edge pulse arriving in any state other than IDLE SHALL be ignored and SHALL set overrun.
REQ-022 flag_clr SHALL clear clip and overrun; if a set event occurs in the same cycle, set SHALL win.
REQ-023 dac_bclk SHALL toggle every BCLK_DIV clk cycles, free-running from reset; one frame SHALL be 32 bclk periods.
REQ-024 dac_lrck SHALL change on dac_bclk falling edges, low for 16 periods (left) and high for 16 periods (right).
REQ-025 On each lrck falling transition the serializer SHALL load mix into a shift register; a mix update in that same clk cycle SHALL be the value loaded.
REQ-026 dac_data SHALL be left-justified and MSB-first, changing on bclk falling edges, with bit 15 in the first bclk period after each lrck transition; the right channel SHALL repeat the same word.

Reset
REQ-027 While aclr_n is low: mix=0, mix_valid=0, clip=0, overrun=0, dac_bclk=0, dac_lrck=0, dac_data=0, accumulator=0, synchronizer flops=0, FSM in IDLE.
REQ-028 Reset assertion mid-MAC SHALL abort the sum with no mix_valid.
REQ-029 After aclr_n deasserts, the first lrck falling transition SHALL load mix=0.

Verification
REQ-030 All samples=16'h1000, all gains=8, one clk_sample rise -> mix_valid 9 clk edges after the rise, mix=16'h2000, clip=0.
REQ-031 All samples=16'h7FFF, all gains=15 -> mix=16'h7FFF, clip=1; then flag_clr -> clip=0.
REQ-032 All samples=16'h8000, all gains=15 -> mix=16'h8000, clip=1.
REQ-033 Second clk_sample rise while the FSM is in MAC2 -> overrun=1, exactly one mix_valid pulse.
REQ-034 mix=16'hA5C3 with BCLK_DIV=4 -> dac_data bit stream 1010010111000011 on both channels; bclk period = 8 clk; frame = 256 clk.
REQ-035 aclr_n low for 1 clk during MAC1 -> all outputs 0 immediately, no mix_valid, next strobe mixes correctly.
